sub_slice_sequencer: RTL and testbench
======================================

// Module: sub_slice_sequencer
// PURPOSE
//   Multi-cycle controller that performs a WIDTH-bit subtraction a - b by
//   sequencing one SIZE-bit subtractor slice over SLICES cycles, LSB slice
//   first, chaining the borrow between slices.
//   Sits between a requester (start/done handshake) and the shared narrow
//   subtractor datapath, so wide operands never need a wide subtractor.
// PARAMETERS
//   SIZE    2  width of one subtractor slice in bits (>=1)
//   SLICES  4  number of slices per operation (>=2); WIDTH = SIZE*SLICES (localparam)
// PORTS
//   clk     in   1      rising-edge clock, only clock in the block
//   rst_n   in   1      synchronous active-low reset
//   start   in   1      request; accepted only while busy==0
//   a       in   WIDTH  minuend, sampled on the accepted start cycle
//   b       in   WIDTH  subtrahend, sampled on the accepted start cycle
//   busy    out  1      high while slices are being processed (RUN state)
//   done    out  1      single-cycle pulse: diff/borrow are final
//   diff    out  WIDTH  result a - b mod 2^WIDTH
//   borrow  out  1      final borrow out of the MSB slice (1 when a < b unsigned)
// BEHAVIOUR
//   - Reset: state=IDLE; busy=0, done=0, diff=0, borrow=0; slice index and
//     borrow-in cleared. Reset has priority over all other inputs.
//   - FSM: IDLE -> RUN on accepted start; RUN -> RUN while idx < SLICES-1;
//     RUN -> DONE after slice SLICES-1; DONE -> IDLE, or DONE -> RUN if start=1.
//   - Accept: start with busy==0 (IDLE or DONE) latches a and b into operand
//     registers, clears diff, borrow-in=0, idx=0, enters RUN next cycle.
//   - start while busy==1 is ignored; operands are not re-sampled.
//   - RUN, per cycle, slice i=idx: {bo,d} = {1'b0,a[i]} - {1'b0,b[i]} - bin
//     (SIZE+1-bit unsigned arithmetic, bo = MSB); d is written into
//     diff[i*SIZE +: SIZE]; bin <= bo; idx <= idx+1.
//   - DONE state: done=1 for exactly one cycle, busy=0, borrow = bo of last slice.
//   - Latency: accepted start in cycle T -> done high in cycle T+SLICES+1.
//   - diff and borrow hold their value after done until the next accepted
//     start (they are then cleared and rebuilt slice by slice).
//   - Partially written diff is visible during RUN. It must not be used
//     before done.
//   - Reset mid-operation: the operation is abandoned and no done pulse
//     is produced. All outputs are at their reset values on the cycle after
//     rst_n is sampled low.
//   - Operands are treated as unsigned. Equal operands give diff=0, borrow=0.
// CONFIGURATION
//   - Macro SUB_SAT_EN.
//   - Defined: saturating mode. At the transition into DONE, if the final
//     borrow is 1, diff is forced to all zeros. borrow is still reported as 1.
//     This adds no extra latency.
//   - Undefined: wrap-around result, diff = (a - b) mod 2^WIDTH.
// TESTING  (SIZE=2, SLICES=4, WIDTH=8)
//   1. Hold rst_n=0 for 2 cycles, then release -> busy=0, done=0, diff=8'h00, borrow=0.
//   2. a=8'h5A, b=8'h21, start at T -> busy high T+1..T+4; done at T+5 only;
//      diff=8'h39, borrow=0.
//   3. a=8'h10, b=8'h01 (borrow ripples through slices 0 and 1) -> diff=8'h0F,
//      borrow=0. a=8'h00, b=8'h01 -> diff=8'hFF, borrow=1, or diff=8'h00,
//      borrow=1 with SUB_SAT_EN.
//   4. Start a=8'hFF, b=8'h0F, then pulse start with a=8'h00, b=8'hFF at T+2
//      -> second start ignored; done at T+5 with diff=8'hF0, borrow=0.
//   5. Start asserted on the done cycle with a=8'h03, b=8'h03 -> busy on the
//      next cycle, done 5 cycles after that done, diff=8'h00, borrow=0.
//   6. Start a=8'h80, b=8'h01; drive rst_n=0 at T+2 -> outputs cleared at
//      T+3, no done pulse, IDLE afterwards; a new start then completes normally.

Source files
------------

// File: rtl/sub_slice_sequencer.sv
// Wide a - b computed on one SIZE-bit subtractor slice, LSB slice first.
// Define SUB_SAT_EN to clamp negative results to zero.
module sub_slice_sequencer #(
    parameter int SIZE   = 2,
    parameter int SLICES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [SIZE*SLICES-1:0] a,
    input  logic [SIZE*SLICES-1:0] b,
    output logic                   busy,
    output logic                   done,
    output logic [SIZE*SLICES-1:0] diff,
    output logic                   borrow
);

    localparam int WIDTH = SIZE * SLICES;
    localparam int IDX_W = $clog2(SLICES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_diff;
    logic [IDX_W-1:0]   r_idx;
    logic               r_bin;
    logic               r_borrow;

    logic               w_accept;
    logic               w_last;
    logic [SIZE-1:0]    w_sa;
    logic [SIZE-1:0]    w_sb;
    logic [SIZE:0]      w_sub;
    logic [SIZE-1:0]    w_d;
    logic               w_bo;

    assign w_accept = start && (r_state != RUN);
    assign w_last   = (r_idx == IDX_W'(SLICES - 1));

    assign w_sa  = r_a[int'(r_idx)*SIZE +: SIZE];
    assign w_sb  = r_b[int'(r_idx)*SIZE +: SIZE];
    assign w_sub = {1'b0, w_sa} - {1'b0, w_sb} - {{SIZE{1'b0}}, r_bin};
    assign w_d   = w_sub[SIZE-1:0];
    assign w_bo  = w_sub[SIZE];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = RUN;
            RUN:     if (w_last) w_next = DONE;
            DONE:    w_next = start ? RUN : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_diff   <= '0;
            r_idx    <= '0;
            r_bin    <= 1'b0;
            r_borrow <= 1'b0;
        end else if (w_accept) begin
            r_a      <= a;
            r_b      <= b;
            r_diff   <= '0;
            r_idx    <= '0;
            r_bin    <= 1'b0;
            r_borrow <= 1'b0;
        end else if (r_state == RUN) begin
            r_diff[int'(r_idx)*SIZE +: SIZE] <= w_d;
            r_bin <= w_bo;
            r_idx <= r_idx + 1'b1;
            if (w_last) begin
                r_borrow <= w_bo;
`ifdef SUB_SAT_EN
                // Negative result clamps on the same edge, no extra cycle.
                if (w_bo) r_diff <= '0;
`endif
            end
        end
    end

    assign busy   = (r_state == RUN);
    assign done   = (r_state == DONE);
    assign diff   = r_diff;
    assign borrow = r_borrow;

endmodule

// File: tb/tb_sub_slice_sequencer.sv
// Directed bench for sub_slice_sequencer (SIZE=2, SLICES=4).
module tb_sub_slice_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       borrow;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

`ifdef SUB_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    sub_slice_sequencer #(.SIZE(2), .SLICES(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] d;
        logic       bo;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits for done; checks busy on every earlier cycle and the latency.
    task automatic wait_done(input int t0, input string nm);
        int busy_bad = 0;
        while (!done && (cyc - t0) < 20) begin
            if (!busy) busy_bad++;
            step();
        end
        chk({nm, " busy_span"}, busy_bad, 0);
        chk({nm, " latency"}, cyc - t0, 5);
        chk({nm, " done"}, done, 1);
        chk({nm, " busy_at_done"}, busy, 0);
    endtask

    task automatic run_op(input logic [7:0] va, input logic [7:0] vb,
                          input logic [7:0] ed, input logic ebo,
                          input string nm);
        int t0;
        a = va;
        b = vb;
        start = 1'b1;
        t0 = cyc;
        step();
        start = 1'b0;
        wait_done(t0, nm);
        chk({nm, " diff"}, diff, ed);
        chk({nm, " borrow"}, borrow, ebo);
        step();
        chk({nm, " done_pulse"}, done, 0);
        chk({nm, " diff_hold"}, diff, ed);
    endtask

    initial begin
        int t0;
        int done_seen;
        vecs[0] = '{8'h5A, 8'h21, 8'h39, 1'b0};
        vecs[1] = '{8'h10, 8'h01, 8'h0F, 1'b0};
        vecs[2] = '{8'h00, 8'h01, 8'hFF, 1'b1};
        vecs[3] = '{8'hFF, 8'h0F, 8'hF0, 1'b0};
        vecs[4] = '{8'h03, 8'h03, 8'h00, 1'b0};
        vecs[5] = '{8'h80, 8'h01, 8'h7F, 1'b0};
        vecs[6] = '{8'h01, 8'h02, 8'hFF, 1'b1};
        vecs[7] = '{8'hFF, 8'hFF, 8'h00, 1'b0};
        vecs[8] = '{8'hC3, 8'h3C, 8'h87, 1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        a = 8'h00;
        b = 8'h00;
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst diff", diff, 8'h00);
        chk("rst borrow", borrow, 0);

        for (int i = 0; i < 9; i++) begin
            logic [7:0] ed;
            ed = (SAT && vecs[i].bo) ? 8'h00 : vecs[i].d;
            run_op(vecs[i].a, vecs[i].b, ed, vecs[i].bo,
                   $sformatf("vec%0d", i));
        end

        // Start while busy is ignored.
        a = 8'hFF;
        b = 8'h0F;
        start = 1'b1;
        t0 = cyc;
        step();
        start = 1'b0;
        step();
        a = 8'h00;
        b = 8'hFF;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(t0, "busy_ign");
        chk("busy_ign diff", diff, 8'hF0);
        chk("busy_ign borrow", borrow, 0);

        // Back-to-back start on the done cycle.
        a = 8'h03;
        b = 8'h03;
        start = 1'b1;
        t0 = cyc;
        step();
        start = 1'b0;
        chk("b2b busy_next", busy, 1);
        chk("b2b diff_cleared", diff[7:4], 4'h0);
        wait_done(t0, "b2b");
        chk("b2b diff", diff, 8'h00);
        chk("b2b borrow", borrow, 0);
        step();

        // Reset mid-operation.
        a = 8'h80;
        b = 8'h01;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        chk("midrst busy", busy, 0);
        chk("midrst done", done, 0);
        chk("midrst diff", diff, 8'h00);
        chk("midrst borrow", borrow, 0);
        rst_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (done || busy) done_seen++;
        end
        chk("midrst idle", done_seen, 0);
        run_op(8'h80, 8'h01, 8'h7F, 1'b0, "post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
